// File: rtl/drive_pkg.sv
// Shared types and arithmetic helpers for the differential drive mixer.
// The helpers work on a wide signed type; callers size-cast the results.
package drive_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } drive_state_t;

    localparam int SPD_W_DEF = 10;

    // Signed per-channel speed at the default SPD_W (one extra bit for sign)
    typedef logic signed [SPD_W_DEF:0] spd_t;

    typedef logic signed [31:0] wide_t;

    function automatic wide_t saturate(input wide_t x, input wide_t lim);
        wide_t r;
        if (x > lim) begin
            r = lim;
        end else if (x < -lim) begin
            r = -lim;
        end else begin
            r = x;
        end
        return r;
    endfunction

    function automatic wide_t step_toward(input wide_t cur, input wide_t tgt, input wide_t step);
        wide_t r;
        if (cur < tgt) begin
            r = (cur + step > tgt) ? tgt : cur + step;
        end else if (cur > tgt) begin
            r = (cur - step < tgt) ? tgt : cur - step;
        end else begin
            r = cur;
        end
        return r;
    endfunction

endpackage

// File: rtl/ramp_channel.sv
// One motor channel: clamps the mixed set-point, holds target/current speed,
// ramps current toward target on ticks and splits it into magnitude/direction.
module ramp_channel
    import drive_pkg::*;
#(
    parameter int IN_W      = 9,
    parameter int SPD_W     = 10,
    parameter int MAX_SPEED = 400,
    parameter int RAMP_STEP = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    tick,
    input  logic                    force_zero,
    input  logic                    clear,
    input  logic                    load,
    input  logic signed [IN_W:0]    new_target,
    output logic [SPD_W-1:0]        speed,
    output logic                    dir,
    output logic                    match_d
);

    logic signed [SPD_W:0] tgt_q, tgt_d;
    logic signed [SPD_W:0] cur_q, cur_d;
    logic [SPD_W-1:0]      speed_q, speed_d;
    logic                  dir_q, dir_d;

    // Next target/current; clear wins over load, load over force_zero
    always_comb begin
        tgt_d = tgt_q;
        cur_d = cur_q;
        if (clear) begin
            tgt_d = '0;
            cur_d = '0;
        end else begin
            if (load) begin
                tgt_d = (SPD_W+1)'(saturate(wide_t'(new_target), wide_t'(MAX_SPEED)));
            end else if (force_zero) begin
                tgt_d = '0;
            end else begin
                tgt_d = tgt_q;
            end
            if (tick) begin
                cur_d = (SPD_W+1)'(step_toward(wide_t'(cur_q), wide_t'(tgt_q), wide_t'(RAMP_STEP)));
            end else begin
                cur_d = cur_q;
            end
        end
        speed_d = SPD_W'(cur_d[SPD_W] ? -cur_d : cur_d);
        dir_d   = ~cur_d[SPD_W];
        match_d = (cur_d == tgt_d);
    end

    // Channel state registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tgt_q   <= '0;
            cur_q   <= '0;
            speed_q <= '0;
            dir_q   <= 1'b1;
        end else begin
            tgt_q   <= tgt_d;
            cur_q   <= cur_d;
            speed_q <= speed_d;
            dir_q   <= dir_d;
        end
    end

    assign speed = speed_q;
    assign dir   = dir_q;

endmodule

// File: rtl/diff_drive_ramp.sv
// Differential drive mixer: pitch/yaw to per-channel ramped wheel speeds,
// with a run/stop FSM, ramp tick divider, command watchdog and e-stop.
module diff_drive_ramp
    import drive_pkg::*;
#(
    parameter int                NUM_CH        = 2,
    parameter int                IN_W          = 9,
    parameter int                SPD_W         = 10,
    parameter int                MAX_SPEED     = 400,
    parameter int                RAMP_STEP     = 4,
    parameter int                RAMP_DIV      = 100000,
    parameter int                TIMEOUT_TICKS = 500,
    parameter logic [NUM_CH-1:0] YAW_SIGN      = 2'b01
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      cmd_valid,
    input  logic signed [IN_W-1:0]    cmd_pitch,
    input  logic signed [IN_W-1:0]    cmd_yaw,
    input  logic                      enable,
    input  logic                      estop,
    output logic [NUM_CH*SPD_W-1:0]   speed,
    output logic [NUM_CH-1:0]         dir,
    output logic                      run_en,
    output logic                      at_target,
    output logic                      timed_out
);

    localparam int TICK_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int WD_W   = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(RAMP_DIV - 1);
    localparam logic [WD_W-1:0]   WD_LIMIT  = WD_W'(TIMEOUT_TICKS);

    drive_state_t         state_q, state_d;
    logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic                 run_en_q, at_target_q, at_target_d, timed_out_q, timed_out_d;
    logic                 tick_s, accept_s, expire_s, all_zero_s, force_zero_s;
    logic [NUM_CH-1:0]    match_s;
    logic signed [IN_W:0] pitch_x_s, yaw_x_s;

    assign pitch_x_s = {cmd_pitch[IN_W-1], cmd_pitch};
    assign yaw_x_s   = {cmd_yaw[IN_W-1], cmd_yaw};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic signed [IN_W:0] mix_s;

        // Differential mix; widened by one bit so pitch +/- yaw cannot wrap
        always_comb begin
            if (YAW_SIGN[i]) begin
                mix_s = pitch_x_s + yaw_x_s;
            end else begin
                mix_s = pitch_x_s - yaw_x_s;
            end
        end

        ramp_channel #(
            .IN_W      (IN_W),
            .SPD_W     (SPD_W),
            .MAX_SPEED (MAX_SPEED),
            .RAMP_STEP (RAMP_STEP)
        ) u_ch (
            .clock      (clock),
            .reset_n    (reset_n),
            .tick       (tick_s),
            .force_zero (force_zero_s),
            .clear      (estop),
            .load       (accept_s),
            .new_target (mix_s),
            .speed      (speed[i*SPD_W +: SPD_W]),
            .dir        (dir[i]),
            .match_d    (match_s[i])
        );
    end

    // Control decode and next-state for FSM, tick divider and watchdog
    always_comb begin
        tick_s       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d   = tick_s ? '0 : tick_cnt_q + TICK_W'(1);
        accept_s     = cmd_valid & enable & ~estop;
        expire_s     = (state_q == RUN) && tick_s && ((wd_q + WD_W'(1)) == WD_LIMIT);
        all_zero_s   = (speed == '0);
        force_zero_s = (state_q != RUN);

        if (accept_s || (state_q != RUN)) begin
            wd_d = '0;
        end else if (tick_s) begin
            wd_d = wd_q + WD_W'(1);
        end else begin
            wd_d = wd_q;
        end

        if (accept_s) begin
            timed_out_d = 1'b0;
        end else if (expire_s) begin
            timed_out_d = 1'b1;
        end else begin
            timed_out_d = timed_out_q;
        end

        if (tick_s || estop) begin
            at_target_d = &match_s;
        end else begin
            at_target_d = at_target_q;
        end

        state_d = state_q;
        if (estop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) state_d = RUN;
                    else          state_d = IDLE;
                end
                RUN: begin
                    if (accept_s)      state_d = RUN;
                    else if (expire_s) state_d = STOPPING;
                    else if (!enable)  state_d = STOPPING;
                    else               state_d = RUN;
                end
                STOPPING: begin
                    if (accept_s)        state_d = RUN;
                    else if (all_zero_s) state_d = IDLE;
                    else                 state_d = STOPPING;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM and control registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            wd_q        <= '0;
            run_en_q    <= 1'b0;
            at_target_q <= 1'b1;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            wd_q        <= wd_d;
            run_en_q    <= (state_d != IDLE);
            at_target_q <= at_target_d;
            timed_out_q <= timed_out_d;
        end
    end

    assign run_en    = run_en_q;
    assign at_target = at_target_q;
    assign timed_out = timed_out_q;

endmodule
